// File: rtl/data_sram_responder.sv
// Slave end of the core's data SRAM port: on-chip word memory plus a small confreg
// window (LED, switch, number display, timer with sticky compare interrupt).
module data_sram_responder #(
  parameter int unsigned MEM_AW     = 12,
  parameter logic [15:0] CONFREG_HI = 16'hBFAF,
  parameter int unsigned SW_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data_sram_en,
  input  logic [3:0]      data_sram_wen,
  input  logic [31:0]     data_sram_addr,
  input  logic [31:0]     data_sram_wdata,
  output logic [31:0]     data_sram_rdata,
  input  logic [SW_W-1:0] switch,
  output logic [15:0]     led,
  output logic [31:0]     num_data,
  output logic            timer_irq
);

  typedef enum logic [13:0] {
    REG_LED       = 14'd0,
    REG_SWITCH    = 14'd1,
    REG_NUM       = 14'd2,
    REG_TIMER     = 14'd3,
    REG_TIMER_CMP = 14'd4,
    REG_IRQ_STAT  = 14'd5
  } conf_reg_e;

  logic [31:0]       mem [0:(1<<MEM_AW)-1];
  logic [31:0]       timer;
  logic [31:0]       timer_cmp;
  logic [31:0]       timer_next;

  logic              req_rd;
  logic              req_wr;
  logic              conf_hit;
  logic [13:0]       conf_off;
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0]       sel_val;
  logic [31:0]       wr_val;

  logic              mem_we;
  logic              conf_we;
  logic              led_we;
  logic              num_we;
  logic              timer_we;
  logic              cmp_we;
  logic              irq_clr;
  logic              unused_addr_lsb;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr_lsb = ^data_sram_addr[1:0];

  assign req_rd   = data_sram_en && (data_sram_wen == 4'b0000);
  assign req_wr   = data_sram_en && (data_sram_wen != 4'b0000);
  assign conf_hit = (data_sram_addr[31:16] == CONFREG_HI);
  assign conf_off = data_sram_addr[15:2];
  assign mem_idx  = data_sram_addr[MEM_AW+1:2];

  // The selected target's current value serves both as read data and as the
  // base word that partial-lane writes merge into.
  always_comb begin
    sel_val = '0;
    if (conf_hit) begin
      case (conf_off)
        REG_LED:       sel_val = {16'h0000, led};
        REG_SWITCH:    sel_val = 32'(switch);
        REG_NUM:       sel_val = num_data;
        REG_TIMER:     sel_val = timer;
        REG_TIMER_CMP: sel_val = timer_cmp;
        REG_IRQ_STAT:  sel_val = {31'd0, timer_irq};
        default:       sel_val = '0;
      endcase
    end else begin
      sel_val = mem[mem_idx];
    end
  end

  assign wr_val = byte_merge(sel_val, data_sram_wdata, data_sram_wen);

  assign mem_we   = !rst && req_wr && !conf_hit;
  assign conf_we  = !rst && req_wr && conf_hit;
  assign led_we   = conf_we && (conf_off == REG_LED);
  assign num_we   = conf_we && (conf_off == REG_NUM);
  assign timer_we = conf_we && (conf_off == REG_TIMER);
  assign cmp_we   = conf_we && (conf_off == REG_TIMER_CMP);
  assign irq_clr  = conf_we && (conf_off == REG_IRQ_STAT) &&
                    data_sram_wen[0] && data_sram_wdata[0];

  assign timer_next = timer_we ? wr_val : (timer + 32'd1);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= '0;
      led             <= '0;
      num_data        <= '0;
      timer           <= '0;
      timer_cmp       <= '1;
      timer_irq       <= 1'b0;
    end else begin
      if (req_rd) data_sram_rdata <= sel_val;
      if (led_we) led <= wr_val[15:0];
      if (num_we) num_data <= wr_val;
      if (cmp_we) timer_cmp <= wr_val;
      timer <= timer_next;
      // Set takes priority over a coincident write-1-to-clear.
      if (timer_next == timer_cmp) timer_irq <= 1'b1;
      else if (irq_clr)            timer_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder: memory, confreg window,
// timer wrap, compare interrupt and reset behaviour.
module tb_data_sram_responder;

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_SW    = 32'hBFAF_0004;
  localparam logic [31:0] A_NUM   = 32'hBFAF_0008;
  localparam logic [31:0] A_TMR   = 32'hBFAF_000C;
  localparam logic [31:0] A_CMP   = 32'hBFAF_0010;
  localparam logic [31:0] A_IRQ   = 32'hBFAF_0014;
  localparam logic [31:0] A_UNDEF = 32'hBFAF_0020;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_irq;

  int compared;
  int mismatched;

  data_sram_responder #(
    .MEM_AW    (12),
    .CONFREG_HI(16'hBFAF),
    .SW_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .switch         (sw),
    .led            (led),
    .num_data       (num_data),
    .timer_irq      (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one bus cycle, then return 1 time unit after the capturing edge.
  task automatic bus(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0; wen = 4'b0000; addr = '0; wdata = '0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) bus(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; en = 1'b0; wen = '0; addr = '0; wdata = '0; sw = '0;

    idle(2);
    rst = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    check("rst_irq", {31'd0, timer_irq}, 32'h0);

    idle(3);
    bus(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_after_reset", rdata, 32'd3);

    bus(1'b1, 4'hF, 32'h0000_0100, 32'hAABB_CCDD);
    bus(1'b1, 4'b0010, 32'h0000_0100, 32'h0000_1100);
    check("rdata_hold_on_write", rdata, 32'd3);
    bus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("mem_byte_merge", rdata, 32'hAABB_11DD);

    bus(1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678);
    bus(1'b1, 4'h0, 32'h0000_4000, 32'h0);
    check("mem_alias", rdata, 32'h1234_5678);
    bus(1'b1, 4'h0, A_UNDEF, 32'h0);
    check("conf_undef_read", rdata, 32'h0);

    bus(1'b1, 4'hF, A_TMR, 32'hFFFF_FFFE);
    check("irq_before_wrap", {31'd0, timer_irq}, 32'h0);
    bus(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_fffffffe", rdata, 32'hFFFF_FFFE);
    check("irq_reset_cmp_match", {31'd0, timer_irq}, 32'h1);
    bus(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_ffffffff", rdata, 32'hFFFF_FFFF);
    bus(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_wrap_zero", rdata, 32'h0);
    bus(1'b1, 4'h1, A_IRQ, 32'h1);
    check("irq_w1c", {31'd0, timer_irq}, 32'h0);
    bus(1'b1, 4'h0, A_IRQ, 32'h0);
    check("irq_stat_clear", rdata, 32'h0);

    bus(1'b1, 4'hF, A_CMP, 32'd100);
    bus(1'b1, 4'h0, A_CMP, 32'h0);
    check("cmp_readback", rdata, 32'd100);
    bus(1'b1, 4'hF, A_TMR, 32'd90);
    idle(9);
    check("irq_at_99", {31'd0, timer_irq}, 32'h0);
    idle(1);
    check("irq_at_100", {31'd0, timer_irq}, 32'h1);
    bus(1'b1, 4'h1, A_IRQ, 32'h0);
    check("irq_w0_no_clear", {31'd0, timer_irq}, 32'h1);
    bus(1'b1, 4'h0, A_IRQ, 32'h0);
    check("irq_stat_set", rdata, 32'h1);
    bus(1'b1, 4'h1, A_IRQ, 32'h1);
    check("irq_clear_again", {31'd0, timer_irq}, 32'h0);

    bus(1'b1, 4'hF, A_TMR, 32'd98);
    idle(1);
    check("irq_before_coincide", {31'd0, timer_irq}, 32'h0);
    bus(1'b1, 4'h1, A_IRQ, 32'h1);
    check("irq_set_beats_clear", {31'd0, timer_irq}, 32'h1);

    bus(1'b1, 4'hF, A_LED, 32'hFFFF_A5A5);
    check("led_out", {16'h0, led}, 32'h0000_A5A5);
    sw = 8'h3C;
    bus(1'b1, 4'h0, A_LED, 32'h0);
    check("led_read", rdata, 32'h0000_A5A5);
    bus(1'b1, 4'hF, A_SW, 32'hFFFF_FFFF);
    bus(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_read", rdata, 32'h0000_003C);
    bus(1'b1, 4'b0010, A_LED, 32'h0000_7700);
    check("led_lane1", {16'h0, led}, 32'h0000_77A5);

    bus(1'b1, 4'b1001, A_NUM, 32'h1122_3344);
    check("num_lanes_03", num_data, 32'h1100_0044);
    bus(1'b1, 4'b0110, A_NUM, 32'hAABB_CCDD);
    check("num_lanes_12", num_data, 32'h11BB_CC44);

    rst = 1'b1;
    bus(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
    rst = 1'b0;
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_led", {16'h0, led}, 32'h0);
    check("midrst_num", num_data, 32'h0);
    check("midrst_irq", {31'd0, timer_irq}, 32'h0);
    bus(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_zero_after_rst", rdata, 32'h0);
    bus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("mem_kept_write_dropped", rdata, 32'hAABB_11DD);
    rst = 1'b1;
    bus(1'b1, 4'h0, A_LED, 32'h0);
    rst = 1'b0;
    check("read_in_rst_dropped", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
